// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM:
// state codes, opcodes, datapath mux codes and the control vector type.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // irwrite/pcwrite in FETCH are qualified by mem_ready in the top (gate_rdy)
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       gate_rdy;
        logic       branch;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Pure state -> control vector decode; input-dependent gating lives in mc_controller.
module mc_outdec
    import ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_req  = 1'b1;
                ctl.irwrite  = 1'b1;
                ctl.pcwrite  = 1'b1;
                ctl.gate_rdy = 1'b1;
                ctl.alusrcb  = SRCB_FOUR;
            end
            S_DECODE: ctl.alusrcb = SRCB_IMM2;
            S_MEMADR, S_ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctl.memtoreg = 1'b1;
                ctl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_req  = 1'b1;
                ctl.iord     = 1'b1;
                ctl.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctl.alusrca = 1'b1;
                ctl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctl.regdst   = 1'b1;
                ctl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctl.alusrca = 1'b1;
                ctl.aluop   = ALU_SUB;
                ctl.pcsrc   = PC_ALUOUT;
                ctl.branch  = 1'b1;
            end
            S_ADDIWB: ctl.regwrite = 1'b1;
            S_JUMP: begin
                ctl.pcsrc   = PC_JUMP;
                ctl.pcwrite = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: state register, next-state logic and the
// mem_ready / zero gating of the fetch and branch PC/IR updates.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           pcen,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           illegal_op,
    output logic [3:0]     state_o
);

    state_t state, nxt;
    ctrl_t  ctl;
    logic   run, legal, rdy_ok;

    mc_outdec u_outdec (.state(state), .ctl(ctl));

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    assign legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                   (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                nxt = S_FETCH;
                if (op == OP_LW || op == OP_SW) nxt = S_MEMADR;
                else if (op == OP_RTYPE)        nxt = S_EXEC;
                else if (op == OP_BEQ)          nxt = S_BRANCH;
                else if (op == OP_ADDI)         nxt = S_ADDIEX;
                else if (op == OP_J)            nxt = S_JUMP;
            end
            S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // reset overrides every output so an aborted instruction cannot write
    assign run    = ~reset;
    assign rdy_ok = ~ctl.gate_rdy | mem_ready;

    assign mem_req    = run & ctl.mem_req;
    assign iord       = run & ctl.iord;
    assign memwrite   = run & ctl.memwrite;
    assign irwrite    = run & ctl.irwrite & mem_ready;
    assign pcen       = run & ((ctl.pcwrite & rdy_ok) | (ctl.branch & zero));
    assign regdst     = run & ctl.regdst;
    assign memtoreg   = run & ctl.memtoreg;
    assign regwrite   = run & ctl.regwrite;
    assign alusrca    = run & ctl.alusrca;
    assign alusrcb    = run ? ctl.alusrcb : 2'b00;
    assign pcsrc      = run ? ctl.pcsrc   : 2'b00;
    assign aluop      = run ? ctl.aluop   : 2'b00;
    assign illegal_op = run & (state == S_DECODE) & ~legal;
    assign state_o    = state;

endmodule
